lector_contadores: RTL and testbench



---
 rtl/lector_contadores.sv | 131 +++++++++++++
 tb/tb_lector_contadores.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_contadores.sv
// Readout sequencer for the contadores block: sweeps every channel, captures counts and a running total.
// Optional READ_AUTO_RESTART_EN: start seen in FINISH chains straight into a new sweep.
module lector_contadores #(
    parameter int NUM_CH  = 5,
    parameter int DATA_W  = 5,
    parameter int TOTAL_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic [2:0]               idx,
    output logic                     req,
    output logic [NUM_CH*DATA_W-1:0] counts,
    output logic [TOTAL_W-1:0]       total,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                   state, state_next;
    logic [2:0]               idx_next;
    logic                     req_next;
    logic [NUM_CH*DATA_W-1:0] counts_next;
    logic [TOTAL_W-1:0]       total_next;
    logic                     busy_next;
    logic                     done_next;
    logic                     timeout_err_next;
    logic [TIMER_W-1:0]       timer, timer_next;
    logic                     channel_over;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            req         <= 1'b0;
            counts      <= '0;
            total       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            req         <= req_next;
            counts      <= counts_next;
            total       <= total_next;
            busy        <= busy_next;
            done        <= done_next;
            timeout_err <= timeout_err_next;
            timer       <= timer_next;
        end
    end

    // Every output is computed one state ahead so it is registered in the state it belongs to.
    always_comb begin
        state_next       = state;
        idx_next         = idx;
        req_next         = 1'b0;
        counts_next      = counts;
        total_next       = total;
        done_next        = 1'b0;
        timeout_err_next = timeout_err;
        timer_next       = timer;
        channel_over     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next       = ISSUE;
                    idx_next         = '0;
                    req_next         = 1'b1;
                    counts_next      = '0;
                    total_next       = '0;
                    timeout_err_next = 1'b0;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                timer_next = '0;
            end
            WAIT: begin
                timer_next = timer + TIMER_W'(1);
                // valid wins over a timeout landing in the same cycle.
                if (valid) begin
                    counts_next[idx*DATA_W +: DATA_W] = data_in;
                    total_next   = total + TOTAL_W'(data_in);
                    channel_over = 1'b1;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    timeout_err_next = 1'b1;
                    channel_over     = 1'b1;
                end
                if (channel_over) begin
                    if (idx == 3'(NUM_CH - 1)) begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        idx_next   = idx + 3'd1;
                        req_next   = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
                idx_next   = '0;
`ifdef READ_AUTO_RESTART_EN
                if (start) begin
                    state_next       = ISSUE;
                    req_next         = 1'b1;
                    counts_next      = '0;
                    total_next       = '0;
                    timeout_err_next = 1'b0;
                end
`else
`endif
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_lector_contadores.sv
// Directed self-checking bench for lector_contadores with a reactive contadores responder.
module tb_lector_contadores;

    localparam int NUM_CH  = 5;
    localparam int DATA_W  = 5;
    localparam int TOTAL_W = 8;

    localparam logic [NUM_CH*DATA_W-1:0] NOM_COUNTS = {5'd12, 5'd7, 5'd31, 5'd0, 5'd3};
    localparam logic [NUM_CH*DATA_W-1:0] TMO_COUNTS = {5'd5, 5'd5, 5'd5, 5'd0, 5'd5};

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     valid;
    logic [DATA_W-1:0]        data_in;
    logic [2:0]               idx;
    logic                     req;
    logic [NUM_CH*DATA_W-1:0] counts;
    logic [TOTAL_W-1:0]       total;
    logic                     busy;
    logic                     done;
    logic                     timeout_err;

    logic [DATA_W-1:0] resp_vals [NUM_CH];

    int checks = 0;
    int fails  = 0;

    lector_contadores dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .valid       (valid),
        .data_in     (data_in),
        .idx         (idx),
        .req         (req),
        .counts      (counts),
        .total       (total),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Starts a sweep and plays contadores: answers each req after 'delay' cycles, except silent_ch.
    // Cycle n is the cycle observed at the n-th falling edge after the edge that samples start.
    task automatic drive_sweep(input int delay, input int silent_ch, input int stop_idx,
                               input bit poke_start, input bit hold_start, input int want_done,
                               input int limit, output int first_done, output int second_done,
                               output bit busy_gap, output bit idx_ok);
        int due;
        int due_ch;
        int expect_ch;
        bit poked;
        due = -1; due_ch = 0; expect_ch = 0; poked = 0;
        first_done = -1; second_done = -1; busy_gap = 0; idx_ok = 1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            valid   = 1'b0;
            data_in = '0;
            if (stop_idx >= 0 && busy && req && idx == 3'(stop_idx)) return;
            if (!busy) busy_gap = 1;
            if (req) begin
                if (idx != 3'(expect_ch)) idx_ok = 0;
                expect_ch = (expect_ch + 1) % NUM_CH;
                if (int'(idx) != silent_ch) begin
                    due    = n + delay;
                    due_ch = int'(idx);
                end
            end
            if (done) begin
                if (first_done < 0) first_done = n;
                else second_done = n;
                if (want_done == 1 || second_done >= 0) return;
            end
            if (n == due) begin
                valid   = 1'b1;
                data_in = resp_vals[due_ch];
                due     = -1;
            end
            if (poke_start && !poked && busy && !req && !done) begin
                start = 1'b1;
                poked = 1;
            end
        end
    endtask

    task automatic test_reset;
        int d1, d2;
        bit gap, ok;
        reset = 1'b1; start = 1'b0; valid = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({idx, req, busy, done, timeout_err} !== 7'd0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got idx=%0d req=%b busy=%b done=%b terr=%b, expected all 0",
                     idx, req, busy, done, timeout_err);
        end
        checks++;
        if (counts !== '0 || total !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data: got counts=%h total=%0d, expected 0 and 0", counts, total);
        end
        reset = 1'b0;
        resp_vals = '{5'd3, 5'd0, 5'd31, 5'd7, 5'd12};
        drive_sweep(1, -1, 2, 0, 0, 1, 40, d1, d2, gap, ok);
        checks++;
        if (total !== 8'd3 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midsweep_progress: got total=%0d busy=%b, expected 3 and 1", total, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({idx, req, busy, done, timeout_err} !== 7'd0 || counts !== '0 || total !== '0) begin
            fails++;
            $display("[TB] FAIL midsweep_reset: got idx=%0d req=%b busy=%b done=%b counts=%h total=%0d, expected all 0",
                     idx, req, busy, done, counts, total);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_no_done: got done=%b busy=%b, expected 0 0", done, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int d1, d2;
        bit gap, ok;
        resp_vals = '{5'd3, 5'd0, 5'd31, 5'd7, 5'd12};
        drive_sweep(1, -1, -1, 0, 0, 1, 60, d1, d2, gap, ok);
        checks++;
        if (d1 !== 11) begin
            fails++;
            $display("[TB] FAIL nominal_done_cycle: got %0d, expected 11", d1);
        end
        checks++;
        if (counts !== NOM_COUNTS) begin
            fails++;
            $display("[TB] FAIL nominal_counts: got %h, expected %h", counts, NOM_COUNTS);
        end
        checks++;
        if (total !== 8'd53 || timeout_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL nominal_total: got total=%0d terr=%b, expected 53 and 0", total, timeout_err);
        end
        checks++;
        if (gap !== 1'b0 || ok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL nominal_busy_idx: got busy_gap=%b idx_ok=%b, expected 0 and 1", gap, ok);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || idx !== 3'd0) begin
            fails++;
            $display("[TB] FAIL nominal_after: got done=%b busy=%b idx=%0d, expected 0 0 0", done, busy, idx);
        end
    endtask

    task automatic test_ignored;
        int d1, d2;
        bit gap, ok;
        valid = 1'b1; data_in = 5'd9;
        @(negedge clk);
        valid = 1'b0; data_in = '0;
        @(negedge clk);
        checks++;
        if (counts !== NOM_COUNTS || total !== 8'd53 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_valid: got counts=%h total=%0d busy=%b, expected %h 53 0",
                     counts, total, busy, NOM_COUNTS);
        end
        drive_sweep(1, -1, -1, 1, 0, 1, 60, d1, d2, gap, ok);
        checks++;
        if (d1 !== 11 || counts !== NOM_COUNTS) begin
            fails++;
            $display("[TB] FAIL wait_start_sweep: got done_cycle=%0d counts=%h, expected 11 %h", d1, counts, NOM_COUNTS);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wait_start_norestart: got busy=%b req=%b, expected 0 0", busy, req);
        end
    endtask

    task automatic test_slow;
        int d1, d2;
        bit gap, ok;
        resp_vals = '{5'd3, 5'd0, 5'd31, 5'd7, 5'd12};
        drive_sweep(4, -1, -1, 0, 0, 1, 80, d1, d2, gap, ok);
        checks++;
        if (d1 !== 26) begin
            fails++;
            $display("[TB] FAIL slow_done_cycle: got %0d, expected 26", d1);
        end
        checks++;
        if (counts !== NOM_COUNTS || total !== 8'd53) begin
            fails++;
            $display("[TB] FAIL slow_data: got counts=%h total=%0d, expected %h 53", counts, total, NOM_COUNTS);
        end
        checks++;
        if (gap !== 1'b0 || ok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL slow_busy: got busy_gap=%b idx_ok=%b, expected 0 1", gap, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int d1, d2;
        bit gap, ok;
        resp_vals = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5};
        drive_sweep(1, 1, -1, 0, 0, 1, 120, d1, d2, gap, ok);
        checks++;
        if (d1 !== 25) begin
            fails++;
            $display("[TB] FAIL timeout_done_cycle: got %0d, expected 25", d1);
        end
        checks++;
        if (counts !== TMO_COUNTS || total !== 8'd20) begin
            fails++;
            $display("[TB] FAIL timeout_data: got counts=%h total=%0d, expected %h 20", counts, total, TMO_COUNTS);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL timeout_flag: got %b, expected 1", timeout_err);
        end
        @(negedge clk);
        drive_sweep(1, -1, -1, 0, 0, 1, 60, d1, d2, gap, ok);
        checks++;
        if (timeout_err !== 1'b0 || total !== 8'd25) begin
            fails++;
            $display("[TB] FAIL timeout_clear: got terr=%b total=%0d, expected 0 25", timeout_err, total);
        end
        @(negedge clk);
    endtask

    task automatic test_auto_restart;
        int d1, d2;
        bit gap, ok;
        resp_vals = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        drive_sweep(1, -1, -1, 0, 1, 2, 80, d1, d2, gap, ok);
        start = 1'b0;
        checks++;
        if (d1 !== 11) begin
            fails++;
            $display("[TB] FAIL restart_first_done: got %0d, expected 11", d1);
        end
`ifdef READ_AUTO_RESTART_EN
        checks++;
        if (d2 !== 22 || gap !== 1'b0) begin
            fails++;
            $display("[TB] FAIL restart_second_done: got cycle=%0d busy_gap=%b, expected 22 0", d2, gap);
        end
`else
        checks++;
        if (d2 !== 23 || gap !== 1'b1) begin
            fails++;
            $display("[TB] FAIL restart_second_done: got cycle=%0d busy_gap=%b, expected 23 1", d2, gap);
        end
`endif
        checks++;
        if (total !== 8'd15 || ok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL restart_total: got total=%0d idx_ok=%b, expected 15 1", total, ok);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_ignored;
        test_slow;
        test_timeout;
        test_auto_restart;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
